// File: rtl/sdram_if_pkg.sv
// sdram_if_pkg: shared types and helpers for the sdram rd/wr burst request interface.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//   state_t  responder/controller FSM states
//   grant_t  round-robin arbiter history (which side won the last contest)
//   col_inc  next word address of a burst, wrapping inside the column field
package sdram_if_pkg;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  // Wide enough for RD_LATENCY-1 with RD_LATENCY up to 8.
  localparam int LAT_W  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_BURST = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  // Increment only the low colbits of addr; bank/row bits above stay fixed.
  function automatic logic [31:0] col_inc(input logic [31:0] addr, input int colbits);
    logic [31:0] mask;
    mask = (32'd1 << colbits) - 32'd1;
    return (addr & ~mask) | ((addr + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/sdram_bram_responder_if.sv
// sdram_bram_responder_if: rd/wr burst request bus between an initiator and the sdram responder.
// Latency: n/a (wires only).
// Backpressure: req is held by the initiator until acked; the responder paces via rd_ack/wr_ack.
//   master: drives rd_addr/rd_len/rd_req and wr_addr/wr_len/wr_data/wr_req
//   slave : drives rd_ack/rd_data/rd_rdy and wr_ack
interface sdram_bram_responder_if #(
  parameter int AW = 20
);

  logic [AW-1:0]                    rd_addr;
  logic [sdram_if_pkg::LEN_W-1:0]   rd_len;
  logic                             rd_req;
  logic                             rd_ack;
  logic [sdram_if_pkg::DATA_W-1:0]  rd_data;
  logic                             rd_rdy;

  logic [AW-1:0]                    wr_addr;
  logic [sdram_if_pkg::LEN_W-1:0]   wr_len;
  logic [sdram_if_pkg::DATA_W-1:0]  wr_data;
  logic                             wr_req;
  logic                             wr_ack;

  modport master (
    output rd_addr, rd_len, rd_req,
    input  rd_ack, rd_data, rd_rdy,
    output wr_addr, wr_len, wr_data, wr_req,
    input  wr_ack
  );

  modport slave (
    input  rd_addr, rd_len, rd_req,
    output rd_ack, rd_data, rd_rdy,
    input  wr_addr, wr_len, wr_data, wr_req,
    output wr_ack
  );

endinterface

// File: rtl/bram_sp_16.sv
// bram_sp_16: single-port 2^MEMBITS x 16 block RAM, synchronous read, no reset.
// Latency: read data appears one cycle after the address; write commits at the clock edge.
// Backpressure: none; one access per cycle.
//   clk in, we in (write enable), addr in [MEMBITS], wdata in [16], rdata out [16]
module bram_sp_16 #(
  parameter int MEMBITS = 12
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [MEMBITS-1:0]                  addr,
  input  logic [sdram_if_pkg::DATA_W-1:0]     wdata,
  output logic [sdram_if_pkg::DATA_W-1:0]     rdata
);

  logic [sdram_if_pkg::DATA_W-1:0] mem [0:(1<<MEMBITS)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdram_bram_responder.sv
// sdram_bram_responder: BRAM-backed stand-in for the sdram controller on the rd/wr burst bus.
// Latency: first rd_rdy RD_LATENCY cycles after rd_ack; first wr_ack one cycle after acceptance.
// Backpressure: requests wait in IDLE until granted; bursts run back-to-back with no stalls.
//   clk, reset_n (async active-low)
//   bus : slave side of sdram_bram_responder_if (rd_* read burst, wr_* write burst)
//   RD_LATENCY legal range 1..8; AW = BANKBITS+ROWBITS+COLBITS must not exceed 32.
module sdram_bram_responder
  import sdram_if_pkg::*;
#(
  parameter int BANKBITS   = 1,
  parameter int ROWBITS    = 11,
  parameter int COLBITS    = 8,
  parameter int MEMBITS    = 12,
  parameter int RD_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sdram_bram_responder_if.slave     bus
);

  localparam int AW = BANKBITS + ROWBITS + COLBITS;

  state_t              state, state_nxt;
  grant_t              last_grant, last_grant_nxt;
  logic [AW-1:0]       addr_q, addr_nxt;
  logic [LEN_W-1:0]    rem_q, rem_nxt;
  logic [LAT_W-1:0]    lat_q, lat_nxt;

  logic                grant_rd, grant_wr;
  logic                ram_we;
  logic [MEMBITS-1:0]  ram_idx;
  logic [DATA_W-1:0]   ram_rdata;
  logic                rd_rdy;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return AW'(col_inc(32'(a), COLBITS));
  endfunction

  // Round-robin arbiter. History only moves on a real contest, so an
  // uncontested grant never changes who wins the next collision.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE) begin
      if (bus.rd_req && bus.wr_req) begin
        grant_rd = (last_grant == GRANT_WR);
        grant_wr = (last_grant == GRANT_RD);
      end else begin
        grant_rd = bus.rd_req;
        grant_wr = bus.wr_req;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_WR;
      addr_q     <= '0;
      rem_q      <= '0;
      lat_q      <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      addr_q     <= addr_nxt;
      rem_q      <= rem_nxt;
      lat_q      <= lat_nxt;
    end
  end

  // addr_q always holds the address the RAM should see next. A read word is
  // fetched one cycle before its rd_rdy, so addr_q advances as each fetch is
  // issued; a write word is stored in the same cycle as its wr_ack.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    addr_nxt       = addr_q;
    rem_nxt        = rem_q;
    lat_nxt        = lat_q;
    ram_we         = 1'b0;
    ram_idx        = addr_q[MEMBITS-1:0];

    unique case (state)
      IDLE: begin
        if (grant_rd) begin
          if (bus.wr_req) begin
            last_grant_nxt = GRANT_RD;
          end
          rem_nxt = bus.rd_len;
          if (RD_LATENCY == 1) begin
            // No wait state: word 0 is fetched in the ack cycle itself.
            ram_idx   = bus.rd_addr[MEMBITS-1:0];
            addr_nxt  = next_addr(bus.rd_addr);
            state_nxt = RD_BURST;
          end else begin
            addr_nxt  = bus.rd_addr;
            lat_nxt   = LAT_W'(RD_LATENCY - 1);
            state_nxt = RD_WAIT;
          end
        end else if (grant_wr) begin
          if (bus.rd_req) begin
            last_grant_nxt = GRANT_WR;
          end
          addr_nxt  = bus.wr_addr;
          rem_nxt   = bus.wr_len;
          state_nxt = WR_BURST;
        end
      end

      RD_WAIT: begin
        if (lat_q == LAT_W'(1)) begin
          // Final wait cycle: word 0 is fetched now.
          addr_nxt  = next_addr(addr_q);
          state_nxt = RD_BURST;
        end else begin
          lat_nxt = lat_q - LAT_W'(1);
        end
      end

      RD_BURST: begin
        if (rem_q == '0) begin
          state_nxt = IDLE;
        end else begin
          rem_nxt  = rem_q - LEN_W'(1);
          addr_nxt = next_addr(addr_q);
        end
      end

      WR_BURST: begin
        ram_we   = 1'b1;
        addr_nxt = next_addr(addr_q);
        if (rem_q == '0) begin
          state_nxt = IDLE;
        end else begin
          rem_nxt = rem_q - LEN_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  bram_sp_16 #(
    .MEMBITS (MEMBITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (bus.wr_data),
    .rdata (ram_rdata)
  );

  assign rd_rdy = (state == RD_BURST);

  // State is forced to IDLE while reset is low, but a held rd_req would
  // still reach rd_ack through the arbiter; gate it so reset is silent.
  assign bus.rd_ack  = reset_n & grant_rd;
  assign bus.rd_rdy  = rd_rdy;
  assign bus.rd_data = rd_rdy ? ram_rdata : '0;
  assign bus.wr_ack  = (state == WR_BURST);

endmodule

// File: tb/tb_sdram_bram_responder.sv
// tb_sdram_bram_responder: directed bench for sdram_bram_responder (RD_LATENCY 3 and 1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_bram_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // sel routes requests to dut0 (latency 3) or dut1 (latency 1).
  bit          sel = 1'b0;
  logic [19:0] rd_addr_b = '0;
  logic [3:0]  rd_len_b = '0;
  logic        rd_req_b = 1'b0;
  logic [19:0] wr_addr_b = '0;
  logic [3:0]  wr_len_b = '0;
  logic [15:0] wr_data_b = '0;
  logic        wr_req_b = 1'b0;

  logic        rd_ack_o, rd_rdy_o, wr_ack_o;
  logic [15:0] rd_data_o;

  sdram_bram_responder_if #(.AW(20)) m0 ();
  sdram_bram_responder_if #(.AW(20)) m1 ();

  assign m0.rd_addr = rd_addr_b;
  assign m0.rd_len  = rd_len_b;
  assign m0.rd_req  = rd_req_b & ~sel;
  assign m0.wr_addr = wr_addr_b;
  assign m0.wr_len  = wr_len_b;
  assign m0.wr_data = wr_data_b;
  assign m0.wr_req  = wr_req_b & ~sel;

  assign m1.rd_addr = rd_addr_b;
  assign m1.rd_len  = rd_len_b;
  assign m1.rd_req  = rd_req_b & sel;
  assign m1.wr_addr = wr_addr_b;
  assign m1.wr_len  = wr_len_b;
  assign m1.wr_data = wr_data_b;
  assign m1.wr_req  = wr_req_b & sel;

  assign rd_ack_o  = sel ? m1.rd_ack  : m0.rd_ack;
  assign rd_rdy_o  = sel ? m1.rd_rdy  : m0.rd_rdy;
  assign rd_data_o = sel ? m1.rd_data : m0.rd_data;
  assign wr_ack_o  = sel ? m1.wr_ack  : m0.wr_ack;

  sdram_bram_responder #(.RD_LATENCY(3)) dut0 (.clk(clk), .reset_n(reset_n), .bus(m0));
  sdram_bram_responder #(.RD_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(m1));

  int vec_cnt = 0;
  int miscmp_cnt = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write burst using exp_q as the data words; request issued from IDLE.
  task automatic wr_burst(input string tag, input logic [19:0] a, input logic [3:0] l);
    int k, n, first, last;
    wr_addr_b = a; wr_len_b = l; wr_data_b = exp_q[0]; wr_req_b = 1'b1;
    k = 0; n = 0; first = -1; last = -1;
    while (k <= int'(l) && n < 40) begin
      #2;
      if (wr_ack_o) begin
        if (first < 0) first = n;
        last = n;
        k++;
      end
      step();
      n++;
      if (k <= int'(l)) wr_data_b = exp_q[k];
    end
    wr_req_b = 1'b0;
    chk({tag, "_first_ack"}, first, 1);
    chk({tag, "_ack_span"}, last - first, 32'(l));
    chk({tag, "_ack_count"}, k, int'(l) + 1);
  endtask

  // Read burst; expects immediate rd_ack, word 0 exactly lat cycles later, data = exp_q.
  task automatic rd_burst(input string tag, input logic [19:0] a, input logic [3:0] l, input int lat);
    int waits;
    bit acked;
    rd_addr_b = a; rd_len_b = l; rd_req_b = 1'b1;
    acked = 1'b0; waits = 0;
    while (!acked && waits < 20) begin
      #2;
      acked = rd_ack_o;
      if (acked) chk({tag, "_rdy_at_ack"}, rd_rdy_o, 0);
      step();
      if (!acked) waits++;
    end
    rd_req_b = 1'b0;
    chk({tag, "_ack_wait"}, waits, 0);
    for (int c = 1; c < lat; c++) begin
      #2;
      chk($sformatf("%s_early_c%0d", tag, c), rd_rdy_o, 0);
      step();
    end
    for (int k = 0; k <= int'(l); k++) begin
      #2;
      chk($sformatf("%s_rdy_w%0d", tag, k), rd_rdy_o, 1);
      chk($sformatf("%s_data_w%0d", tag, k), rd_data_o, exp_q[k]);
      step();
    end
    #2;
    chk({tag, "_rdy_after"}, rd_rdy_o, 0);
    step();
  endtask

  // Both requests raised together; records the cycle of the first rd_ack and wr_ack.
  task automatic contend(input string tag, input int exp_rd, input int exp_wr);
    int first_rd, first_wr;
    rd_addr_b = 20'h00020; rd_len_b = 4'd0; rd_req_b = 1'b1;
    wr_addr_b = 20'h00030; wr_len_b = 4'd0; wr_data_b = 16'hC0DE; wr_req_b = 1'b1;
    first_rd = -1; first_wr = -1;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (rd_ack_o && first_rd < 0) first_rd = c;
      if (wr_ack_o && first_wr < 0) first_wr = c;
      step();
      if (first_rd >= 0) rd_req_b = 1'b0;
      if (first_wr >= 0) wr_req_b = 1'b0;
    end
    rd_req_b = 1'b0; wr_req_b = 1'b0;
    chk({tag, "_rd_ack_cyc"}, first_rd, exp_rd);
    chk({tag, "_wr_ack_cyc"}, first_wr, exp_wr);
  endtask

  initial begin
    int pulses;

    // Reset with both requests held: nothing may respond.
    reset_n = 1'b0; rd_req_b = 1'b1; wr_req_b = 1'b1;
    step(); step();
    #2;
    chk("rst_rd_ack", rd_ack_o, 0);
    chk("rst_wr_ack", wr_ack_o, 0);
    chk("rst_rd_rdy", rd_rdy_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    step();
    rd_req_b = 1'b0; wr_req_b = 1'b0;
    reset_n = 1'b1;
    step();

    // Round robin: first contest to read, second to write.
    contend("rr1", 0, 5);
    contend("rr2", 2, 1);

    // Basic write then read back, latency 3.
    exp_q = '{16'h1111, 16'h1112, 16'h1113, 16'h1114};
    wr_burst("wr10", 20'h00010, 4'd3);
    rd_burst("rd10", 20'h00010, 4'd3, 3);

    // Column wrap inside row 5; row 6 col 0 must be untouched.
    exp_q = '{16'h6666};
    wr_burst("wr600", 20'h00600, 4'd0);
    exp_q = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    wr_burst("wr5fe", 20'h005FE, 4'd3);
    exp_q = '{16'hA003, 16'hA004};
    rd_burst("rd500", 20'h00500, 4'd1, 3);
    exp_q = '{16'hA001, 16'hA002};
    rd_burst("rd5fe", 20'h005FE, 4'd1, 3);
    exp_q = '{16'h6666};
    rd_burst("rd600", 20'h00600, 4'd0, 3);

    // Alias: 2^12 + 7 and 7 are the same BRAM word.
    exp_q = '{16'h7777};
    wr_burst("wr_alias", 20'h01007, 4'd0);
    rd_burst("rd_alias", 20'h00007, 4'd0, 3);

    // Latency-1 instance, single-word read.
    sel = 1'b1;
    step();
    exp_q = '{16'hBEEF};
    wr_burst("l1_wr", 20'h00042, 4'd0);
    rd_burst("l1_rd", 20'h00042, 4'd0, 1);
    sel = 1'b0;
    step();

    // Reset during word 2 of a 16-word read.
    rd_addr_b = 20'h00010; rd_len_b = 4'hF; rd_req_b = 1'b1;
    #2;
    chk("mid_ack", rd_ack_o, 1);
    step();
    rd_req_b = 1'b0;
    step(); step();
    #2;
    chk("mid_w0", rd_data_o, 16'h1111);
    step();
    #2;
    chk("mid_w1", rd_data_o, 16'h1112);
    step();
    #1;
    chk("mid_w2_rdy", rd_rdy_o, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy", rd_rdy_o, 0);
    chk("mid_rst_data", rd_data_o, 0);
    step();
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (rd_rdy_o) pulses++;
      step();
    end
    chk("mid_no_pulses", pulses, 0);
    exp_q = '{16'h1111, 16'h1112, 16'h1113, 16'h1114};
    rd_burst("post_rst", 20'h00010, 4'd3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
